pre_spike_counter_bank: RTL and testbench

//  Banked presynaptic spike counter for the FF learning core. Holds one CNT_W counter per input neuron.

---
 rtl/snn_ff_pkg.sv | 14 +
 rtl/pre_cnt_ram.sv | 26 ++
 rtl/pre_spike_counter_bank.sv | 148 ++++++++++++++
 tb/tb_pre_spike_counter_bank.sv | 230 +++++++++++++++++++++++
 4 files changed

// File: rtl/snn_ff_pkg.sv
// Shared types and default widths for the FF learning core.
package snn_ff_pkg;

  localparam int unsigned PRE_CNT_W  = 8;
  localparam int unsigned PRE_ADDR_W = 8;
  localparam int unsigned PRE_N_NEUR = 256;

  typedef enum logic [1:0] {
    IDLE,
    DRAIN,
    CLEAR
  } pre_cnt_state_t;

endpackage

// File: rtl/pre_cnt_ram.sv
// Simple dual-port counter RAM: one write port, one synchronous read port.
// Reads return the pre-write contents when read and write addresses collide.
module pre_cnt_ram
  import snn_ff_pkg::*;
#(
  parameter int unsigned N_NEUR = PRE_N_NEUR,
  parameter int unsigned ADDR_W = PRE_ADDR_W,
  parameter int unsigned CNT_W  = PRE_CNT_W
) (
  input  logic              clk,
  input  logic              wr_en,
  input  logic [ADDR_W-1:0] wr_addr,
  input  logic [CNT_W-1:0]  wr_data,
  input  logic [ADDR_W-1:0] rd_addr,
  output logic [CNT_W-1:0]  rd_data
);

  logic [CNT_W-1:0] mem [N_NEUR];

  // Registered read and write; no reset so the array maps onto block RAM.
  always_ff @(posedge clk) begin
    if (wr_en) mem[wr_addr] <= wr_data;
    rd_data <= mem[rd_addr];
  end

endmodule

// File: rtl/pre_spike_counter_bank.sv
// Banked presynaptic spike counter with a 2-stage read-modify-write pipeline,
// a clear sweep on time-reference events, and a shared readback port.
// Build option: define PRE_CNT_SAT_EN for saturating counters and sat_flag.
module pre_spike_counter_bank
  import snn_ff_pkg::*;
#(
  parameter int unsigned N_NEUR = PRE_N_NEUR,
  parameter int unsigned ADDR_W = PRE_ADDR_W,
  parameter int unsigned CNT_W  = PRE_CNT_W
) (
  input  logic              CLK,
  input  logic              RST,
  input  logic              ev_valid,
  output logic              ev_ready,
  input  logic [ADDR_W-1:0] ev_addr,
  input  logic              ev_spike,
  input  logic              tref_req,
  output logic              tref_busy,
  input  logic              rd_en,
  input  logic [ADDR_W-1:0] rd_addr,
  output logic              rd_ack,
  output logic              rd_valid,
  output logic [CNT_W-1:0]  rd_data,
  output logic              sat_flag
);

  localparam logic [ADDR_W:0] ADDR_LIM = (ADDR_W+1)'(N_NEUR);
  localparam logic [ADDR_W-1:0] LAST_IDX = ADDR_W'(N_NEUR - 1);

  function automatic logic in_range(input logic [ADDR_W-1:0] a);
    return {1'b0, a} < ADDR_LIM;
  endfunction

  pre_cnt_state_t state, state_nxt;

  logic              ev_acc;
  logic              s1_valid, s1_spike, s1_inr, s1_fwd, s1_wr;
  logic [ADDR_W-1:0] s1_addr;
  logic [CNT_W-1:0]  s1_fwd_val, s1_cur, s1_nxt;
  logic              rd_inr, rd_fwd;
  logic [CNT_W-1:0]  rd_fwd_val;
  logic [ADDR_W-1:0] sweep_idx;
  logic              ram_wr_en;
  logic [ADDR_W-1:0] ram_wr_addr, ram_rd_addr;
  logic [CNT_W-1:0]  ram_wr_data, ram_rd_data;

  assign ev_ready  = (state == IDLE) && !RST;
  assign ev_acc    = ev_valid && ev_ready;
  assign rd_ack    = rd_en && !ev_acc && (state == IDLE);
  assign tref_busy = (state != IDLE);

  // The RAM read of a same-address write one cycle earlier is stale, so the
  // S1 value is captured alongside the address and substituted here.
  assign s1_cur = s1_fwd ? s1_fwd_val : ram_rd_data;
  assign s1_wr  = s1_valid && s1_inr;

`ifdef PRE_CNT_SAT_EN
  logic sat_hit;
  assign sat_hit = s1_wr && s1_spike && (s1_cur == '1);
  assign s1_nxt  = (s1_spike && (s1_cur != '1)) ? s1_cur + 1'b1 : s1_cur;
`else
  assign s1_nxt  = s1_cur + CNT_W'(s1_spike);
`endif

  // The sweep and the pipeline never write in the same cycle (DRAIN empties S1).
  assign ram_wr_en   = s1_wr || (state == CLEAR);
  assign ram_wr_addr = (state == CLEAR) ? sweep_idx : s1_addr;
  assign ram_wr_data = (state == CLEAR) ? '0 : s1_nxt;
  assign ram_rd_addr = ev_acc ? ev_addr : rd_addr;

  assign rd_data = (rd_valid && rd_inr) ? (rd_fwd ? rd_fwd_val : ram_rd_data) : '0;

  pre_cnt_ram #(
    .N_NEUR (N_NEUR),
    .ADDR_W (ADDR_W),
    .CNT_W  (CNT_W)
  ) u_ram (
    .clk     (CLK),
    .wr_en   (ram_wr_en),
    .wr_addr (ram_wr_addr),
    .wr_data (ram_wr_data),
    .rd_addr (ram_rd_addr),
    .rd_data (ram_rd_data)
  );

  // Pipeline S1 and readback registers, including forwarding captures.
  always_ff @(posedge CLK or posedge RST) begin
    if (RST) begin
      s1_valid   <= 1'b0;
      s1_addr    <= '0;
      s1_spike   <= 1'b0;
      s1_inr     <= 1'b0;
      s1_fwd     <= 1'b0;
      s1_fwd_val <= '0;
      rd_valid   <= 1'b0;
      rd_inr     <= 1'b0;
      rd_fwd     <= 1'b0;
      rd_fwd_val <= '0;
    end else begin
      s1_valid   <= ev_acc;
      s1_addr    <= ev_addr;
      s1_spike   <= ev_spike;
      s1_inr     <= in_range(ev_addr);
      s1_fwd     <= s1_wr && (s1_addr == ev_addr);
      s1_fwd_val <= s1_nxt;
      rd_valid   <= rd_ack;
      rd_inr     <= in_range(rd_addr);
      rd_fwd     <= s1_wr && (s1_addr == rd_addr);
      rd_fwd_val <= s1_nxt;
    end
  end

  // State register.
  always_ff @(posedge CLK or posedge RST) begin
    if (RST) state <= IDLE;
    else     state <= state_nxt;
  end

  // Next-state logic: IDLE -> DRAIN on tref_req, DRAIN -> CLEAR once S1 is empty.
  always_comb begin
    state_nxt = state;
    unique case (state)
      IDLE:    if (tref_req) state_nxt = DRAIN;
      DRAIN:   if (!s1_valid) state_nxt = CLEAR;
      CLEAR:   if (sweep_idx == LAST_IDX) state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  // Sweep address counter, held at zero outside CLEAR.
  always_ff @(posedge CLK or posedge RST) begin
    if (RST)                 sweep_idx <= '0;
    else if (state == CLEAR) sweep_idx <= sweep_idx + 1'b1;
    else                     sweep_idx <= '0;
  end

`ifdef PRE_CNT_SAT_EN
  // Sticky saturation flag, cleared on the first sweep write.
  always_ff @(posedge CLK or posedge RST) begin
    if (RST)                                     sat_flag <= 1'b0;
    else if (state == CLEAR && sweep_idx == '0)  sat_flag <= 1'b0;
    else if (sat_hit)                            sat_flag <= 1'b1;
  end
`else
  assign sat_flag = 1'b0;
`endif

endmodule

// File: tb/tb_pre_spike_counter_bank.sv
// Directed self-checking bench for pre_spike_counter_bank.
module tb_pre_spike_counter_bank;

  logic       CLK = 1'b0;
  logic       RST;
  logic       ev_valid, ev_ready, ev_spike;
  logic [7:0] ev_addr;
  logic       tref_req, tref_busy;
  logic       rd_en, rd_ack, rd_valid;
  logic [7:0] rd_addr, rd_data;
  logic       sat_flag;

  int n_tests = 0;
  int n_fail  = 0;

  pre_spike_counter_bank #(
    .N_NEUR (256),
    .ADDR_W (8),
    .CNT_W  (8)
  ) dut (
    .CLK       (CLK),
    .RST       (RST),
    .ev_valid  (ev_valid),
    .ev_ready  (ev_ready),
    .ev_addr   (ev_addr),
    .ev_spike  (ev_spike),
    .tref_req  (tref_req),
    .tref_busy (tref_busy),
    .rd_en     (rd_en),
    .rd_addr   (rd_addr),
    .rd_ack    (rd_ack),
    .rd_valid  (rd_valid),
    .rd_data   (rd_data),
    .sat_flag  (sat_flag)
  );

  always #5 CLK = ~CLK;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0d expected %0d", tag, got, exp);
    end
  endtask

  task automatic drive_ev(input logic [7:0] a, input logic s);
    @(negedge CLK);
    ev_valid = 1'b1;
    ev_addr  = a;
    ev_spike = s;
  endtask

  task automatic ev_idle();
    @(negedge CLK);
    ev_valid = 1'b0;
    ev_spike = 1'b0;
  endtask

  task automatic spikes(input logic [7:0] a, input int n);
    for (int i = 0; i < n; i++) drive_ev(a, 1'b1);
    ev_idle();
  endtask

  task automatic do_read(input logic [7:0] a, output logic [7:0] d, output logic ok);
    @(negedge CLK);
    rd_en   = 1'b1;
    rd_addr = a;
    #1 ok = rd_ack;
    @(negedge CLK);
    rd_en = 1'b0;
    ok    = ok && rd_valid;
    d     = rd_data;
  endtask

  task automatic read_chk(input string tag, input logic [7:0] a, input logic [7:0] exp);
    logic [7:0] d;
    logic       ok;
    do_read(a, d, ok);
    chk(tag, d, exp);
    chk({tag, "_hs"}, ok, 1);
  endtask

  // Issues tref_req (optionally with a spike in the same cycle), holds a spike
  // request pending while busy, and optionally re-pulses tref_req mid-sweep.
  task automatic do_tref(input logic with_ev, input logic [7:0] a, input int poke_at,
                         output int busy, output int rdy_bad);
    @(negedge CLK);
    tref_req = 1'b1;
    if (with_ev) begin
      ev_valid = 1'b1;
      ev_addr  = a;
      ev_spike = 1'b1;
      #1 chk("tref_ev_ready", ev_ready, 1);
    end
    @(negedge CLK);
    tref_req = 1'b0;
    busy     = 0;
    rdy_bad  = 0;
    while (tref_busy && busy < 400) begin
      busy++;
      if (ev_ready) rdy_bad++;
      tref_req = (busy == poke_at);
      ev_valid = 1'b1;
      ev_addr  = 8'd3;
      ev_spike = 1'b1;
      @(negedge CLK);
    end
    tref_req = 1'b0;
    ev_valid = 1'b0;
    ev_spike = 1'b0;
  endtask

  initial begin
    #1_000_000;
    $display("FAIL watchdog: got timeout expected $finish");
    $fatal(1, "timeout");
  end

  initial begin
    int busy, rdy_bad, bad;
    logic [7:0] d;
    logic ok;

    RST = 1'b1;
    ev_valid = 1'b0; ev_addr = '0; ev_spike = 1'b0;
    tref_req = 1'b0; rd_en = 1'b0; rd_addr = '0;
    repeat (3) @(negedge CLK);
    chk("rst_ev_ready", ev_ready, 0);
    chk("rst_tref_busy", tref_busy, 0);
    chk("rst_rd_valid", rd_valid, 0);
    chk("rst_rd_data", rd_data, 0);
    chk("rst_sat_flag", sat_flag, 0);
    RST = 1'b0;
    #1 chk("post_rst_ev_ready", ev_ready, 1);

    // Initial sweep: 1 drain cycle + 256 clear cycles.
    do_tref(1'b0, 8'd0, 0, busy, rdy_bad);
    chk("init_busy_cycles", busy, 257);
    chk("init_ready_low", rdy_bad, 0);
    bad = 0;
    for (int i = 0; i < 256; i++) begin
      do_read(8'(i), d, ok);
      if (d != 8'd0 || !ok) bad++;
    end
    chk("sweep_zero", bad, 0);

    // Back-to-back spikes to one address.
    spikes(8'd5, 3);
    read_chk("addr5_b2b", 8'd5, 8'd3);

    // Interleaved addresses with a no-op touch.
    drive_ev(8'd7, 1'b1);
    drive_ev(8'd9, 1'b0);
    drive_ev(8'd7, 1'b1);
    drive_ev(8'd9, 1'b1);
    ev_idle();
    read_chk("addr7_alt", 8'd7, 8'd2);
    read_chk("addr9_alt", 8'd9, 8'd1);

    // Read issued the cycle after a spike to the same address.
    drive_ev(8'd20, 1'b1);
    @(negedge CLK);
    ev_valid = 1'b0;
    rd_en    = 1'b1;
    rd_addr  = 8'd20;
    #1 chk("fwd_rd_ack", rd_ack, 1);
    @(negedge CLK);
    rd_en = 1'b0;
    chk("fwd_rd_data", rd_data, 1);

    // Event wins over a simultaneous read.
    @(negedge CLK);
    ev_valid = 1'b1; ev_addr = 8'd40; ev_spike = 1'b1;
    rd_en = 1'b1; rd_addr = 8'd5;
    #1 chk("arb_rd_ack", rd_ack, 0);
    chk("arb_ev_ready", ev_ready, 1);
    @(negedge CLK);
    ev_valid = 1'b0; ev_spike = 1'b0; rd_en = 1'b0;
    chk("arb_rd_valid", rd_valid, 0);
    read_chk("addr40", 8'd40, 8'd1);

    // Overflow behaviour.
    spikes(8'd0, 260);
`ifdef PRE_CNT_SAT_EN
    read_chk("addr0_ovf", 8'd0, 8'd255);
    chk("sat_flag_ovf", sat_flag, 1);
`else
    read_chk("addr0_ovf", 8'd0, 8'd4);
    chk("sat_flag_ovf", sat_flag, 0);
`endif

    // tref_req together with an accepted spike; second tref_req mid-sweep ignored.
    spikes(8'd3, 10);
    read_chk("addr3_pre", 8'd3, 8'd10);
    do_tref(1'b1, 8'd3, 50, busy, rdy_bad);
    chk("ev_tref_busy_cycles", busy, 258);
    chk("ev_tref_ready_low", rdy_bad, 0);
    chk("ev_tref_sat_clear", sat_flag, 0);
    read_chk("addr3_post", 8'd3, 8'd0);
    read_chk("addr0_post", 8'd0, 8'd0);
    read_chk("addr40_post", 8'd40, 8'd0);

    // Reset asserted at sweep index 100.
    @(negedge CLK);
    tref_req = 1'b1;
    @(negedge CLK);
    tref_req = 1'b0;
    repeat (101) @(negedge CLK);
    chk("mid_sweep_busy", tref_busy, 1);
    RST = 1'b1;
    #1 chk("mid_rst_busy", tref_busy, 0);
    chk("mid_rst_ev_ready", ev_ready, 0);
    chk("mid_rst_rd_valid", rd_valid, 0);
    @(negedge CLK);
    RST = 1'b0;
    #1 chk("mid_rst_release_ready", ev_ready, 1);
    chk("mid_rst_release_busy", tref_busy, 0);

    do_tref(1'b0, 8'd0, 0, busy, rdy_bad);
    chk("final_busy_cycles", busy, 257);
    spikes(8'd255, 2);
    read_chk("addr255", 8'd255, 8'd2);
    read_chk("addr5_final", 8'd5, 8'd0);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
